rx_cmd_decoder: RTL and testbench

RX_CMD_DECODER -- requirements
Module: rx_cmd_decoder

---
 rtl/rx_cmd_decoder_if.sv | 54 +++++
 rtl/rx_cmd_decoder.sv | 244 ++++++++++++++++++++++++
 tb/tb_rx_cmd_decoder.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rx_cmd_decoder_if.sv
// rx_cmd_decoder_if: bundles the byte-receive, register-file, ALU and
// byte-transmit signals of the UART command decoder.
// The slave modport is the decoder's view; the master modport is the
// surrounding system (UART, register file, ALU) driving the decoder.
interface rx_cmd_decoder_if #(
    parameter int DATA_WIDTH          = 8,
    parameter int REGISTER_FILE_DEPTH = 16
);
    localparam int ADDR_WIDTH = $clog2(REGISTER_FILE_DEPTH);

    logic [DATA_WIDTH-1:0]   rx_data;
    logic                    rx_valid;
    logic                    rx_error;

    logic [ADDR_WIDTH-1:0]   rf_addr;
    logic [DATA_WIDTH-1:0]   rf_wr_data;
    logic                    rf_wr_en;
    logic                    rf_rd_en;
    logic [DATA_WIDTH-1:0]   rf_rd_data;
    logic                    rf_rd_valid;

    logic [3:0]              alu_func;
    logic                    alu_en;
    logic [2*DATA_WIDTH-1:0] alu_result;
    logic                    alu_valid;

    logic [DATA_WIDTH-1:0]   tx_data;
    logic                    tx_valid;
    logic                    tx_ready;

    logic                    busy;

    modport slave (
        input  rx_data, rx_valid, rx_error,
        output rf_addr, rf_wr_data, rf_wr_en, rf_rd_en,
        input  rf_rd_data, rf_rd_valid,
        output alu_func, alu_en,
        input  alu_result, alu_valid,
        output tx_data, tx_valid,
        input  tx_ready,
        output busy
    );

    modport master (
        output rx_data, rx_valid, rx_error,
        input  rf_addr, rf_wr_data, rf_wr_en, rf_rd_en,
        output rf_rd_data, rf_rd_valid,
        input  alu_func, alu_en,
        output alu_result, alu_valid,
        input  tx_data, tx_valid,
        output tx_ready,
        input  busy
    );
endinterface

// File: rtl/rx_cmd_decoder.sv
// rx_cmd_decoder: turns a stream of UART bytes into register-file writes,
// register-file reads and ALU operations, and streams read/ALU results back
// over a valid/ready byte channel.
// Optional feature: define CMD_TIMEOUT_EN to abandon a command whose
// argument bytes stop arriving for TIMEOUT_CYCLES clock cycles.
module rx_cmd_decoder #(
    parameter int DATA_WIDTH          = 8,
    parameter int REGISTER_FILE_DEPTH = 16,
    parameter int TIMEOUT_CYCLES      = 4096
) (
    input  logic ref_clk,
    input  logic reset,
    rx_cmd_decoder_if.slave bus
);
    localparam int ADDR_WIDTH = $clog2(REGISTER_FILE_DEPTH);

    localparam logic [DATA_WIDTH-1:0] CMD_WRITE = DATA_WIDTH'(8'hAA);
    localparam logic [DATA_WIDTH-1:0] CMD_READ  = DATA_WIDTH'(8'hBB);
    localparam logic [DATA_WIDTH-1:0] CMD_ALU   = DATA_WIDTH'(8'hCC);
    localparam logic [DATA_WIDTH-1:0] CMD_FUNC  = DATA_WIDTH'(8'hDD);

    typedef enum logic [3:0] {
        IDLE,
        WR_ADDR,
        WR_DATA,
        RD_ADDR,
        RD_WAIT,
        ALU_A,
        ALU_B,
        ALU_FUNC,
        ALU_WAIT,
        TX_LO,
        TX_HI
    } stateT;

    stateT                 r_state;
    stateT                 w_nextState;

    logic [ADDR_WIDTH-1:0] r_rfAddr,    w_rfAddr;
    logic [DATA_WIDTH-1:0] r_rfWrData,  w_rfWrData;
    logic                  r_rfWrEn,    w_rfWrEn;
    logic                  r_rfRdEn,    w_rfRdEn;
    logic [3:0]            r_aluFunc,   w_aluFunc;
    logic                  r_aluEn,     w_aluEn;
    logic [DATA_WIDTH-1:0] r_txData,    w_txData;
    logic                  r_txValid,   w_txValid;
    logic [DATA_WIDTH-1:0] r_resultHi,  w_resultHi;

    logic                  w_accept;
    logic                  w_abort;
    logic                  w_txDone;
    logic                  w_timeoutHit;

    assign w_accept = bus.rx_valid & ~bus.rx_error;
    assign w_abort  = bus.rx_valid &  bus.rx_error;
    assign w_txDone = r_txValid & bus.tx_ready;

`ifdef CMD_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_timeoutCnt;
    logic             w_argState;

    assign w_argState   = (r_state == WR_ADDR) || (r_state == WR_DATA) ||
                          (r_state == RD_ADDR) || (r_state == ALU_A)   ||
                          (r_state == ALU_B)   || (r_state == ALU_FUNC);
    assign w_timeoutHit = w_argState && !bus.rx_valid &&
                          (r_timeoutCnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Silence counter: runs only while waiting for an argument byte and
    // restarts on any byte or whenever the FSM is outside argument states.
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            r_timeoutCnt <= '0;
        end else if (!w_argState || bus.rx_valid || w_timeoutHit) begin
            r_timeoutCnt <= '0;
        end else begin
            r_timeoutCnt <= r_timeoutCnt + CNT_W'(1);
        end
    end
`else
    assign w_timeoutHit = 1'b0;
`endif

    // State and output registers; strobes come from the next-state logic
    // and therefore last exactly one cycle.
    always_ff @(posedge ref_clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_rfAddr   <= '0;
            r_rfWrData <= '0;
            r_rfWrEn   <= 1'b0;
            r_rfRdEn   <= 1'b0;
            r_aluFunc  <= '0;
            r_aluEn    <= 1'b0;
            r_txData   <= '0;
            r_txValid  <= 1'b0;
            r_resultHi <= '0;
        end else begin
            r_state    <= w_nextState;
            r_rfAddr   <= w_rfAddr;
            r_rfWrData <= w_rfWrData;
            r_rfWrEn   <= w_rfWrEn;
            r_rfRdEn   <= w_rfRdEn;
            r_aluFunc  <= w_aluFunc;
            r_aluEn    <= w_aluEn;
            r_txData   <= w_txData;
            r_txValid  <= w_txValid;
            r_resultHi <= w_resultHi;
        end
    end

    // Command decode: argument states consume good bytes and abort on a
    // flagged byte; wait and transmit states ignore incoming bytes.
    always_comb begin
        w_nextState = r_state;
        w_rfAddr    = r_rfAddr;
        w_rfWrData  = r_rfWrData;
        w_rfWrEn    = 1'b0;
        w_rfRdEn    = 1'b0;
        w_aluFunc   = r_aluFunc;
        w_aluEn     = 1'b0;
        w_txData    = r_txData;
        w_txValid   = r_txValid;
        w_resultHi  = r_resultHi;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (bus.rx_data == CMD_WRITE) begin
                        w_nextState = WR_ADDR;
                    end else if (bus.rx_data == CMD_READ) begin
                        w_nextState = RD_ADDR;
                    end else if (bus.rx_data == CMD_ALU) begin
                        w_nextState = ALU_A;
                    end else if (bus.rx_data == CMD_FUNC) begin
                        w_nextState = ALU_FUNC;
                    end
                end
            end
            WR_ADDR: begin
                if (w_abort) begin
                    w_nextState = IDLE;
                end else if (w_accept) begin
                    w_rfAddr    = bus.rx_data[ADDR_WIDTH-1:0];
                    w_nextState = WR_DATA;
                end
            end
            WR_DATA: begin
                if (w_abort) begin
                    w_nextState = IDLE;
                end else if (w_accept) begin
                    w_rfWrData  = bus.rx_data;
                    w_rfWrEn    = 1'b1;
                    w_nextState = IDLE;
                end
            end
            RD_ADDR: begin
                if (w_abort) begin
                    w_nextState = IDLE;
                end else if (w_accept) begin
                    w_rfAddr    = bus.rx_data[ADDR_WIDTH-1:0];
                    w_rfRdEn    = 1'b1;
                    w_nextState = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (bus.rf_rd_valid) begin
                    w_txData    = bus.rf_rd_data;
                    w_txValid   = 1'b1;
                    w_nextState = TX_HI;
                end
            end
            ALU_A: begin
                if (w_abort) begin
                    w_nextState = IDLE;
                end else if (w_accept) begin
                    w_rfAddr    = ADDR_WIDTH'(0);
                    w_rfWrData  = bus.rx_data;
                    w_rfWrEn    = 1'b1;
                    w_nextState = ALU_B;
                end
            end
            ALU_B: begin
                if (w_abort) begin
                    w_nextState = IDLE;
                end else if (w_accept) begin
                    w_rfAddr    = ADDR_WIDTH'(1);
                    w_rfWrData  = bus.rx_data;
                    w_rfWrEn    = 1'b1;
                    w_nextState = ALU_FUNC;
                end
            end
            ALU_FUNC: begin
                if (w_abort) begin
                    w_nextState = IDLE;
                end else if (w_accept) begin
                    w_aluFunc   = bus.rx_data[3:0];
                    w_aluEn     = 1'b1;
                    w_nextState = ALU_WAIT;
                end
            end
            ALU_WAIT: begin
                if (bus.alu_valid) begin
                    w_txData    = bus.alu_result[DATA_WIDTH-1:0];
                    w_resultHi  = bus.alu_result[2*DATA_WIDTH-1:DATA_WIDTH];
                    w_txValid   = 1'b1;
                    w_nextState = TX_LO;
                end
            end
            TX_LO: begin
                if (w_txDone) begin
                    w_txData    = r_resultHi;
                    w_nextState = TX_HI;
                end
            end
            TX_HI: begin
                if (w_txDone) begin
                    w_txValid   = 1'b0;
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
                w_txValid   = 1'b0;
            end
        endcase

        if (w_timeoutHit) begin
            w_nextState = IDLE;
        end
    end

    assign bus.rf_addr    = r_rfAddr;
    assign bus.rf_wr_data = r_rfWrData;
    assign bus.rf_wr_en   = r_rfWrEn;
    assign bus.rf_rd_en   = r_rfRdEn;
    assign bus.alu_func   = r_aluFunc;
    assign bus.alu_en     = r_aluEn;
    assign bus.tx_data    = r_txData;
    assign bus.tx_valid   = r_txValid;
    assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_rx_cmd_decoder.sv
// tb_rx_cmd_decoder: directed bench for rx_cmd_decoder. Bytes are driven one
// cycle at a time, read/ALU returns are pulsed by hand, and a negedge monitor
// logs every strobe and every completed TX transfer for later comparison.
// Build with CMD_TIMEOUT_EN defined to exercise the command timeout.
module tb_rx_cmd_decoder;

    logic ref_clk;
    logic reset;

    int checks;
    int errors;

    logic [3:0] wrAddrQ[$];
    logic [7:0] wrDataQ[$];
    logic [7:0] txQ[$];
    int         rdCount;
    logic [3:0] lastRdAddr;
    int         aluCount;
    logic [3:0] lastAluFunc;
    int         strobeClash;

    rx_cmd_decoder_if #(.DATA_WIDTH(8), .REGISTER_FILE_DEPTH(16)) bus ();

    rx_cmd_decoder #(
        .DATA_WIDTH(8),
        .REGISTER_FILE_DEPTH(16),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .ref_clk(ref_clk),
        .reset(reset),
        .bus(bus)
    );

    // Free-running 10 ns clock.
    initial begin
        ref_clk = 1'b0;
        forever #5 ref_clk = ~ref_clk;
    end

    // Records what the register file, ALU and TX consumer would observe.
    always @(negedge ref_clk) begin
        if (!reset) begin
            if (bus.rf_wr_en) begin
                wrAddrQ.push_back(bus.rf_addr);
                wrDataQ.push_back(bus.rf_wr_data);
            end
            if (bus.rf_rd_en) begin
                rdCount++;
                lastRdAddr = bus.rf_addr;
            end
            if (bus.alu_en) begin
                aluCount++;
                lastAluFunc = bus.alu_func;
            end
            if (bus.tx_valid && bus.tx_ready) begin
                txQ.push_back(bus.tx_data);
            end
            if (int'(bus.rf_wr_en) + int'(bus.rf_rd_en) + int'(bus.alu_en) > 1) begin
                strobeClash++;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge ref_clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [7:0] data, input logic err);
        @(posedge ref_clk);
        #1;
        bus.rx_data  = data;
        bus.rx_error = err;
        bus.rx_valid = 1'b1;
        @(posedge ref_clk);
        #1;
        bus.rx_valid = 1'b0;
        bus.rx_error = 1'b0;
    endtask

    task automatic returnRead(input logic [7:0] data);
        @(posedge ref_clk);
        #1;
        bus.rf_rd_data  = data;
        bus.rf_rd_valid = 1'b1;
        @(posedge ref_clk);
        #1;
        bus.rf_rd_valid = 1'b0;
    endtask

    task automatic returnAlu(input logic [15:0] result);
        @(posedge ref_clk);
        #1;
        bus.alu_result = result;
        bus.alu_valid  = 1'b1;
        @(posedge ref_clk);
        #1;
        bus.alu_valid = 1'b0;
    endtask

    initial begin
        checks      = 0;
        errors      = 0;
        rdCount     = 0;
        aluCount    = 0;
        lastRdAddr  = '0;
        lastAluFunc = '0;
        strobeClash = 0;

        bus.rx_data     = '0;
        bus.rx_valid    = 1'b0;
        bus.rx_error    = 1'b0;
        bus.rf_rd_data  = '0;
        bus.rf_rd_valid = 1'b0;
        bus.alu_result  = '0;
        bus.alu_valid   = 1'b0;
        bus.tx_ready    = 1'b0;

        reset = 1'b1;
        idle(3);
        checkOutput("rst_busy",     32'(bus.busy),       32'h0);
        checkOutput("rst_tx_valid", 32'(bus.tx_valid),   32'h0);
        checkOutput("rst_rf_addr",  32'(bus.rf_addr),    32'h0);
        checkOutput("rst_wr_en",    32'(bus.rf_wr_en),   32'h0);
        checkOutput("rst_tx_data",  32'(bus.tx_data),    32'h0);
        reset = 1'b0;
        idle(1);

        // Register write: AA 05 3C
        applyStimulus(8'hAA, 1'b0);
        applyStimulus(8'h05, 1'b0);
        checkOutput("wr_busy_mid", 32'(bus.busy), 32'h1);
        applyStimulus(8'h3C, 1'b0);
        idle(2);
        checkOutput("wr_count", 32'(wrAddrQ.size()), 32'd1);
        checkOutput("wr_addr",  32'(wrAddrQ[0]),     32'h5);
        checkOutput("wr_data",  32'(wrDataQ[0]),     32'h3C);
        checkOutput("wr_no_tx", 32'(txQ.size()),     32'd0);
        checkOutput("wr_busy",  32'(bus.busy),       32'h0);

        // Register read: BB 05, data 3C returned
        bus.tx_ready = 1'b1;
        applyStimulus(8'hBB, 1'b0);
        applyStimulus(8'h05, 1'b0);
        idle(1);
        checkOutput("rd_count", 32'(rdCount),    32'd1);
        checkOutput("rd_addr",  32'(lastRdAddr), 32'h5);
        checkOutput("rd_busy",  32'(bus.busy),   32'h1);
        returnRead(8'h3C);
        idle(2);
        checkOutput("rd_tx_count", 32'(txQ.size()), 32'd1);
        checkOutput("rd_tx_byte",  32'(txQ[0]),     32'h3C);
        checkOutput("rd_busy_end", 32'(bus.busy),   32'h0);

        // ALU: CC 12 34 00, result 0x0046, consumer stalls 10 cycles
        bus.tx_ready = 1'b0;
        applyStimulus(8'hCC, 1'b0);
        applyStimulus(8'h12, 1'b0);
        applyStimulus(8'h34, 1'b0);
        applyStimulus(8'h00, 1'b0);
        idle(1);
        checkOutput("alu_wr_count", 32'(wrAddrQ.size()), 32'd3);
        checkOutput("alu_wrA_addr", 32'(wrAddrQ[1]),     32'h0);
        checkOutput("alu_wrA_data", 32'(wrDataQ[1]),     32'h12);
        checkOutput("alu_wrB_addr", 32'(wrAddrQ[2]),     32'h1);
        checkOutput("alu_wrB_data", 32'(wrDataQ[2]),     32'h34);
        checkOutput("alu_en_count", 32'(aluCount),       32'd1);
        checkOutput("alu_func0",    32'(lastAluFunc),    32'h0);
        returnAlu(16'h0046);
        checkOutput("alu_tx_valid", 32'(bus.tx_valid), 32'h1);
        for (int i = 0; i < 10; i++) begin
            idle(1);
            checkOutput("alu_hold_data", 32'(bus.tx_data), 32'h46);
        end
        checkOutput("alu_hold_no_xfer", 32'(txQ.size()), 32'd1);
        bus.tx_ready = 1'b1;
        idle(3);
        checkOutput("alu_tx_count", 32'(txQ.size()), 32'd3);
        checkOutput("alu_tx_lo",    32'(txQ[1]),     32'h46);
        checkOutput("alu_tx_hi",    32'(txQ[2]),     32'h00);
        checkOutput("alu_busy_end", 32'(bus.busy),   32'h0);

        // Function only: DD 02, result 0xABCD
        applyStimulus(8'hDD, 1'b0);
        applyStimulus(8'h02, 1'b0);
        idle(1);
        checkOutput("func_en_count", 32'(aluCount),       32'd2);
        checkOutput("func_code",     32'(lastAluFunc),    32'h2);
        checkOutput("func_no_wr",    32'(wrAddrQ.size()), 32'd3);
        returnAlu(16'hABCD);
        idle(3);
        checkOutput("func_tx_count", 32'(txQ.size()), 32'd5);
        checkOutput("func_tx_lo",    32'(txQ[3]),     32'hCD);
        checkOutput("func_tx_hi",    32'(txQ[4]),     32'hAB);

        // Error abort mid-write, then a clean read
        applyStimulus(8'hAA, 1'b0);
        applyStimulus(8'h07, 1'b0);
        applyStimulus(8'h99, 1'b1);
        idle(2);
        checkOutput("err_busy",  32'(bus.busy),       32'h0);
        checkOutput("err_no_wr", 32'(wrAddrQ.size()), 32'd3);
        applyStimulus(8'hBB, 1'b0);
        applyStimulus(8'h07, 1'b0);
        idle(1);
        checkOutput("err_rd_count", 32'(rdCount),    32'd2);
        checkOutput("err_rd_addr",  32'(lastRdAddr), 32'h7);
        returnRead(8'h5A);
        idle(2);
        checkOutput("err_rd_tx", 32'(txQ[5]), 32'h5A);

        // Unknown command and flagged command byte leave IDLE untouched
        applyStimulus(8'h42, 1'b0);
        idle(1);
        checkOutput("unknown_busy", 32'(bus.busy), 32'h0);
        applyStimulus(8'hAA, 1'b1);
        idle(1);
        checkOutput("err_cmd_busy", 32'(bus.busy), 32'h0);

        // Stray returns outside their wait states are ignored
        returnRead(8'hEE);
        returnAlu(16'h1111);
        idle(2);
        checkOutput("stray_tx_valid", 32'(bus.tx_valid), 32'h0);
        checkOutput("stray_busy",     32'(bus.busy),     32'h0);

        // Bytes arriving during RD_WAIT are dropped
        applyStimulus(8'hBB, 1'b0);
        applyStimulus(8'h01, 1'b0);
        applyStimulus(8'hCC, 1'b0);
        applyStimulus(8'hAA, 1'b0);
        checkOutput("drop_busy", 32'(bus.busy), 32'h1);
        returnRead(8'h77);
        idle(2);
        checkOutput("drop_tx_count", 32'(txQ.size()),     32'd7);
        checkOutput("drop_tx_byte",  32'(txQ[6]),         32'h77);
        checkOutput("drop_no_wr",    32'(wrAddrQ.size()), 32'd3);
        checkOutput("drop_busy_end", 32'(bus.busy),       32'h0);

        // Reset while holding the low result byte
        bus.tx_ready = 1'b0;
        applyStimulus(8'hDD, 1'b0);
        applyStimulus(8'h03, 1'b0);
        returnAlu(16'h1234);
        checkOutput("txlo_valid", 32'(bus.tx_valid), 32'h1);
        checkOutput("txlo_data",  32'(bus.tx_data),  32'h34);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        checkOutput("rst_txlo_valid", 32'(bus.tx_valid), 32'h0);
        checkOutput("rst_txlo_busy",  32'(bus.busy),     32'h0);
        checkOutput("rst_txlo_data",  32'(bus.tx_data),  32'h0);
        checkOutput("rst_txlo_func",  32'(bus.alu_func), 32'h0);
        checkOutput("rst_txlo_wdata", 32'(bus.rf_wr_data), 32'h0);
        bus.tx_ready = 1'b1;
        idle(2);
        checkOutput("rst_txlo_no_xfer", 32'(txQ.size()), 32'd7);

`ifdef CMD_TIMEOUT_EN
        // Silence after AA abandons the command; late 05 is an unknown command
        applyStimulus(8'hAA, 1'b0);
        idle(18);
        checkOutput("tmo_busy", 32'(bus.busy), 32'h0);
        applyStimulus(8'h05, 1'b0);
        idle(1);
        checkOutput("tmo_late_busy", 32'(bus.busy), 32'h0);
        applyStimulus(8'h3C, 1'b0);
        idle(2);
        checkOutput("tmo_no_wr", 32'(wrAddrQ.size()), 32'd3);
`else
        // Without the timeout an argument state waits indefinitely
        applyStimulus(8'hAA, 1'b0);
        idle(40);
        checkOutput("notmo_busy", 32'(bus.busy), 32'h1);
        applyStimulus(8'h09, 1'b0);
        applyStimulus(8'hE1, 1'b0);
        idle(2);
        checkOutput("notmo_wr_count", 32'(wrAddrQ.size()), 32'd4);
        checkOutput("notmo_wr_addr",  32'(wrAddrQ[3]),     32'h9);
        checkOutput("notmo_wr_data",  32'(wrDataQ[3]),     32'hE1);
`endif

        checkOutput("strobe_exclusive", 32'(strobeClash), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
